fragment_writer: RTL

// - Consumer end of the rasterizer fragment stream. Accepts fragment_valid/x/y/lambda/done (no backpressure) and buffers fragments in a FIFO.
// - Clips each fragment to the framebuffer and computes a linear pixel address and an RGB565 colour.
// - Issues framebuffer writes over a req/ack handshake. Signals frame completion once the rasterizer is done and every write has drained.

---
 rtl/fragment_writer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fragment_writer.sv
// Fragment writer: clips rasterizer fragments, queues {addr, colour} in a
// FIFO and drains them to the framebuffer over a req/ack handshake.
// Ports: clk, rst (async, active-high), i_clear, i_color,
//   i_fragment_valid/x/y, i_lambda0..2, i_done, o_fb_req/addr/data,
//   i_fb_ack, o_frame_done, o_overflow, o_pix_count, o_clip_count.
// Option: define SHADE_EN to derive colour from the lambdas instead of
//   i_color.
module fragment_writer #(
  parameter int CORD_WIDTH   = 10,
  parameter int FB_WIDTH     = 640,
  parameter int FB_HEIGHT    = 480,
  parameter int ADDR_WIDTH   = 19,
  parameter int FIFO_DEPTH   = 8,
  parameter int LAMBDA_SHIFT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_clear,
  input  logic [15:0]                      i_color,
  input  logic                             i_fragment_valid,
  input  logic signed [CORD_WIDTH-1:0]     i_fragment_x,
  input  logic signed [CORD_WIDTH-1:0]     i_fragment_y,
  input  logic signed [2*CORD_WIDTH:0]     i_lambda0,
  input  logic signed [2*CORD_WIDTH:0]     i_lambda1,
  input  logic signed [2*CORD_WIDTH:0]     i_lambda2,
  input  logic                             i_done,
  output logic                             o_fb_req,
  output logic [ADDR_WIDTH-1:0]            o_fb_addr,
  output logic [15:0]                      o_fb_data,
  input  logic                             i_fb_ack,
  output logic                             o_frame_done,
  output logic                             o_overflow,
  output logic [CNT_WIDTH-1:0]             o_pix_count,
  output logic [CNT_WIDTH-1:0]             o_clip_count
);

  localparam int LW = 2*CORD_WIDTH+1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH+16;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t                  state_q;
  logic                    req_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             data_q;

  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [PW:0]             cnt_q;

  logic [CNT_WIDTH-1:0]    pix_q, pix_d;
  logic [CNT_WIDTH-1:0]    clip_q, clip_d;
  logic                    ovf_q, ovf_d;
  logic                    pend_q, pend_d;
  logic                    fdone_q, fdone_d;

  logic signed [31:0]      x_s;
  logic signed [31:0]      y_s;
  logic                    in_range;
  logic                    frag_in;
  logic                    frag_clip;
  logic                    full;
  logic                    empty;
  logic                    ack_hs;
  logic                    pop;
  logic                    push;
  logic                    drop;
  logic                    fire;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic [15:0]             colour_c;

  assign x_s = 32'(i_fragment_x);
  assign y_s = 32'(i_fragment_y);

  assign in_range = (x_s >= 0) && (x_s < FB_WIDTH) &&
                    (y_s >= 0) && (y_s < FB_HEIGHT);

  assign frag_in   = i_fragment_valid &  in_range;
  assign frag_clip = i_fragment_valid & ~in_range;

  assign full   = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign ack_hs = req_q & i_fb_ack;

  // IDLE pops whenever data is waiting; REQ only refills on a handshake.
  assign pop  = ~empty & ((state_q == IDLE) | ack_hs);
  // A full FIFO still accepts when the same edge frees a slot.
  assign push = frag_in & (~full | pop);
  assign drop = frag_in & full & ~pop;

  assign addr_c = ADDR_WIDTH'(y_s) * ADDR_WIDTH'(FB_WIDTH)
                + ADDR_WIDTH'(x_s);

`ifdef SHADE_EN
  function automatic logic [5:0] sat(
    input logic signed [LW-1:0] v,
    input logic [5:0]           maxv
  );
    logic signed [LW-1:0] s;
    logic signed [LW-1:0] m;
    s = v >>> LAMBDA_SHIFT;
    m = LW'(maxv);
    if (s[LW-1])    return '0;
    else if (s > m) return maxv;
    else            return s[5:0];
  endfunction

  logic [5:0] r_s, g_s, b_s;
  logic       unused_in;

  assign r_s = sat(i_lambda0, 6'd31);
  assign g_s = sat(i_lambda1, 6'd63);
  assign b_s = sat(i_lambda2, 6'd31);
  assign colour_c  = {r_s[4:0], g_s, b_s[4:0]};
  assign unused_in = ^{r_s[5], b_s[5], i_color};
`else
  logic unused_in;

  assign colour_c  = i_color;
  assign unused_in = ^{i_lambda0, i_lambda1, i_lambda2};
`endif

  // Frame completes only once nothing is queued, in flight or arriving.
  assign fire = pend_q & empty & (state_q == IDLE) & ~push;

  always_comb begin
    pix_d   = pix_q;
    clip_d  = clip_q;
    ovf_d   = ovf_q | drop;
    pend_d  = (pend_q & ~fire) | (i_done & ~pend_q);
    fdone_d = fire;
    if (ack_hs)    pix_d  = pix_q + 1'b1;
    if (frag_clip) clip_d = clip_q + 1'b1;
    if (i_clear) begin
      pix_d  = '0;
      clip_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {addr_c, colour_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            {addr_q, data_q} <= mem_q[rd_ptr_q];
            req_q            <= 1'b1;
            state_q          <= REQ;
          end
        end
        REQ: begin
          if (i_fb_ack) begin
            if (!empty) begin
              {addr_q, data_q} <= mem_q[rd_ptr_q];
            end else begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q   <= '0;
      clip_q  <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      clip_q  <= clip_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      fdone_q <= fdone_d;
    end
  end

  assign o_fb_req     = req_q;
  assign o_fb_addr    = addr_q;
  assign o_fb_data    = data_q;
  assign o_frame_done = fdone_q;
  assign o_overflow   = ovf_q;
  assign o_pix_count  = pix_q;
  assign o_clip_count = clip_q;

endmodule
